// File: rtl/spi_write_controller_if.sv
// spi_write_controller_if: groups the parallel write-request side and the
// SPI wire side of the SPI write controller.
// slave  : the controller itself.
// master : the requester that drives write requests and observes the link.
interface spi_write_controller_if;
  logic        wr_en_in;
  logic [23:0] wr_address_in;
  logic [31:0] wr_data_in;
  logic        busy;
  logic        done;
  logic        sck;
  logic        cs;
  logic        copi;

  modport master (
    output wr_en_in, wr_address_in, wr_data_in,
    input  busy, done, sck, cs, copi
  );

  modport slave (
    input  wr_en_in, wr_address_in, wr_data_in,
    output busy, done, sck, cs, copi
  );
endinterface

// File: rtl/spi_write_controller.sv
// spi_write_controller: SPI mode-0 initiator that sends one 64-bit write
// frame {WRITE_COMMAND, address[23:0], data[31:0]}, MSB first, per accepted
// request. sck, cs and copi are all generated from clk and registered.
// Optional feature macro: SPI_TRAIL_PULSE_EN -- adds one extra sck pulse
// with copi=0 after the last data bit (65 rising edges per frame).
module spi_write_controller #(
  parameter logic [7:0]  WRITE_COMMAND  = 8'hA1,
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned CS_IDLE_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  spi_write_controller_if.slave  bus
);

  // Terminal values of the shared cycle counter (half-period / hold / gap).
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_IDLE_CYCLES - 1);

  // Rising-edge count after which the next falling edge ends the frame.
`ifdef SPI_TRAIL_PULSE_EN
  localparam logic [6:0] LAST_RISE = 7'd65;
`else
  localparam logic [6:0] LAST_RISE = 7'd64;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t      state_r,   state_s;
  logic [7:0]  div_cnt_r, div_cnt_s;
  logic [6:0]  bit_cnt_r, bit_cnt_s;
  logic [63:0] shift_r,   shift_s;
  logic        sck_r,     sck_s;
  logic        cs_r,      cs_s;
  logic        copi_r,    copi_s;
  logic        busy_r,    busy_s;
  logic        done_r,    done_s;
  logic [63:0] load_s;

  assign load_s   = {WRITE_COMMAND, bus.wr_address_in, bus.wr_data_in};

  assign bus.sck  = sck_r;
  assign bus.cs   = cs_r;
  assign bus.copi = copi_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= 8'd0;
      bit_cnt_r <= 7'd0;
      shift_r   <= 64'd0;
      sck_r     <= 1'b0;
      cs_r      <= 1'b1;
      copi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      sck_r     <= sck_s;
      cs_r      <= cs_s;
      copi_r    <= copi_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    sck_s     = sck_r;
    cs_s      = cs_r;
    copi_s    = copi_r;
    busy_s    = busy_r;
    done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.wr_en_in && !busy_r) begin
          // Accept: the first bit goes onto copi together with cs falling.
          state_s   = ST_SHIFT;
          shift_s   = load_s;
          copi_s    = load_s[63];
          cs_s      = 1'b0;
          busy_s    = 1'b1;
          sck_s     = 1'b0;
          div_cnt_s = 8'd0;
          bit_cnt_s = 7'd0;
        end else begin
          cs_s      = 1'b1;
          sck_s     = 1'b0;
          copi_s    = 1'b0;
          busy_s    = 1'b0;
          div_cnt_s = 8'd0;
          bit_cnt_s = 7'd0;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_s = 8'd0;
          sck_s     = ~sck_r;
          if (!sck_r) begin
            // Rising edge: peripheral samples copi now.
            bit_cnt_s = bit_cnt_r + 7'd1;
          end else begin
            // Falling edge: either end the frame or present the next bit.
            if (bit_cnt_r == LAST_RISE) begin
              state_s = ST_HOLD;
            end else begin
              shift_s = {shift_r[62:0], 1'b0};
              copi_s  = shift_r[62];
            end
          end
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      ST_HOLD: begin
        // Keep cs low for one more half-period after the final fall.
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_s = 8'd0;
          cs_s      = 1'b1;
          copi_s    = 1'b0;
          done_s    = 1'b1;
          state_s   = ST_GAP;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      ST_GAP: begin
        // The done cycle is the first of the CS_IDLE_CYCLES gap cycles.
        if (div_cnt_r == GAP_LAST) begin
          div_cnt_s = 8'd0;
          busy_s    = 1'b0;
          state_s   = ST_IDLE;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = 8'd0;
        bit_cnt_s = 7'd0;
        shift_s   = 64'd0;
        sck_s     = 1'b0;
        cs_s      = 1'b1;
        copi_s    = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

endmodule
